// File: rtl/mul_pkg.sv
// Shared types and widths for the requester arbiter in front of the
// radix-4 Booth multiplier.
package mul_pkg;

    localparam int OP_W            = 16;
    localparam int PROD_W          = 32;
    localparam int NREQ_DEFAULT    = 4;
    localparam int TIMEOUT_DEFAULT = 15;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT,
        ACK,
        DRAIN,
        RESP
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin winner selection: one-hot grant of the first set request bit
// found searching upward from ptr, wrapping at NREQ.
module rr_arbiter #(
    parameter  int NREQ  = 4,
    localparam int PTR_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  grant
);

    int idx;

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        grant = '0;
        idx   = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NREQ;
            if (req[idx]) begin
                grant = NREQ'(1) << idx;
            end
        end
    end

endmodule

// File: rtl/mul_arbiter.sv
// Shares one radix-4 Booth multiplier among NREQ requesters: round-robin
// grant, start/ack handshake with timeout, drain, then a held response.
module mul_arbiter
    import mul_pkg::*;
#(
    parameter  int NREQ    = NREQ_DEFAULT,
    parameter  int TIMEOUT = TIMEOUT_DEFAULT,
    localparam int ID_W    = $clog2(NREQ)
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic signed [OP_W-1:0]   req_a [NREQ],
    input  logic signed [OP_W-1:0]   req_b [NREQ],
    output logic                     rsp_valid,
    output logic [ID_W-1:0]          rsp_id,
    output logic signed [PROD_W-1:0] rsp_result,
    output logic                     rsp_err,
    input  logic                     rsp_ready,
    output logic                     mul_start,
    output logic                     mul_ack,
    output logic                     mul_irq_enable,
    output logic signed [OP_W-1:0]   mul_data_a,
    output logic signed [OP_W-1:0]   mul_data_b,
    input  logic                     mul_busy,
    input  logic                     mul_irq,
    input  logic signed [PROD_W-1:0] mul_result
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t                   state;
    state_t                   state_nxt;
    logic [NREQ-1:0]          grant;
    logic [ID_W-1:0]          rr_ptr;
    logic [ID_W-1:0]          win_idx;
    logic [ID_W-1:0]          id_q;
    logic [CNT_W-1:0]         wait_cnt;
    logic signed [OP_W-1:0]   op_a;
    logic signed [OP_W-1:0]   op_b;
    logic signed [PROD_W-1:0] result_q;
    logic                     err_q;
    logic                     accept;
    logic                     timeout_hit;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                win_idx = ID_W'(i);
            end
        end
    end

    assign accept         = (state == IDLE) && resetn && (|grant);
    assign timeout_hit    = (wait_cnt == CNT_W'(TIMEOUT - 1));
    assign mul_irq_enable = resetn;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = '0;
        mul_start  = 1'b0;
        mul_ack    = 1'b0;
        mul_data_a = '0;
        mul_data_b = '0;
        rsp_valid  = 1'b0;
        rsp_id     = '0;
        rsp_result = '0;
        rsp_err    = 1'b0;

        // Operands stay on the multiplier bus for the whole operation.
        if (state inside {START, WAIT, ACK, DRAIN}) begin
            mul_data_a = op_a;
            mul_data_b = op_b;
        end

        case (state)
            IDLE: begin
                req_ready = resetn ? grant : '0;
                if (accept) begin
                    state_nxt = START;
                end
            end
            START: begin
                mul_start = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (mul_irq || timeout_hit) begin
                    state_nxt = ACK;
                end
            end
            ACK: begin
                mul_ack   = 1'b1;
                state_nxt = DRAIN;
            end
            DRAIN: begin
                if (!mul_busy) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid  = 1'b1;
                rsp_id     = id_q;
                rsp_result = result_q;
                rsp_err    = err_q;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rr_ptr   <= '0;
            wait_cnt <= '0;
        end else begin
            if (accept) begin
                rr_ptr <= (win_idx == ID_W'(NREQ - 1)) ? '0 : win_idx + ID_W'(1);
            end
            if (state == START) begin
                wait_cnt <= '0;
            end else if (state == WAIT && !mul_irq && !timeout_hit) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
        end
    end

    // Datapath registers carry no reset; outputs are gated by state instead.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_a <= req_a[win_idx];
            op_b <= req_b[win_idx];
            id_q <= win_idx;
        end
        if (state == WAIT) begin
            if (mul_irq) begin
                result_q <= mul_result;
                err_q    <= 1'b0;
            end else if (timeout_hit) begin
                result_q <= '0;
                err_q    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mul_arbiter.sv
// Bench for mul_arbiter: behavioural multiplier model plus a round-robin and
// product reference model driven by directed and random scenarios.
module tb_mul_arbiter;

    localparam int NREQ    = 4;
    localparam int TIMEOUT = 15;

    logic                clk = 1'b0;
    logic                resetn;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic signed [15:0]  req_a [NREQ];
    logic signed [15:0]  req_b [NREQ];
    logic                rsp_valid;
    logic [1:0]          rsp_id;
    logic signed [31:0]  rsp_result;
    logic                rsp_err;
    logic                rsp_ready;
    logic                mul_start;
    logic                mul_ack;
    logic                mul_irq_enable;
    logic signed [15:0]  mul_data_a;
    logic signed [15:0]  mul_data_b;
    logic                mul_busy;
    logic                mul_irq;
    logic signed [31:0]  mul_result;

    int total = 0;
    int bad   = 0;

    mul_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_a          (req_a),
        .req_b          (req_b),
        .rsp_valid      (rsp_valid),
        .rsp_id         (rsp_id),
        .rsp_result     (rsp_result),
        .rsp_err        (rsp_err),
        .rsp_ready      (rsp_ready),
        .mul_start      (mul_start),
        .mul_ack        (mul_ack),
        .mul_irq_enable (mul_irq_enable),
        .mul_data_a     (mul_data_a),
        .mul_data_b     (mul_data_b),
        .mul_busy       (mul_busy),
        .mul_irq        (mul_irq),
        .mul_result     (mul_result)
    );

    always #5 clk = ~clk;

    // Multiplier model: busy from start until ack, irq after mul_lat cycles.
    logic m_busy = 1'b0;
    logic m_irq  = 1'b0;
    int   m_res  = 0;
    int   m_cnt  = 0;
    int   mul_lat  = 8;
    bit   suppress = 1'b0;

    always @(posedge clk) begin
        if (!resetn) begin
            m_busy <= 1'b0;
            m_irq  <= 1'b0;
            m_cnt  <= 0;
        end else if (mul_ack) begin
            m_busy <= 1'b0;
            m_irq  <= 1'b0;
        end else if (mul_start) begin
            m_busy <= 1'b1;
            m_cnt  <= 1;
            m_irq  <= !suppress && (mul_lat == 1);
            m_res  <= int'(mul_data_a) * int'(mul_data_b);
        end else if (m_busy && !m_irq) begin
            m_cnt <= m_cnt + 1;
            if (!suppress && (m_cnt + 1 >= mul_lat)) m_irq <= 1'b1;
        end
    end

    assign mul_busy   = m_busy;
    assign mul_irq    = m_irq;
    assign mul_result = m_res;

    // Reference model state: round-robin pointer.
    int exp_ptr = 0;

    function automatic int exp_pick(input logic [NREQ-1:0] m);
        for (int k = 0; k < NREQ; k++) begin
            if (m[(exp_ptr + k) % NREQ]) return (exp_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    // Observations from the last do_op call.
    int                 g_gnt, g_wait, g_lat, g_acks, g_starts;
    int                 g_data_bad, g_stab_bad, g_rdy_bad;
    logic [1:0]         g_id;
    logic signed [31:0] g_res;
    logic               g_err, g_after_valid;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn    = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        tick();
        tick();
        resetn  = 1'b1;
        exp_ptr = 0;
        #1;
    endtask

    // Drives one full transaction and records what the DUT did.
    task automatic do_op(input logic [NREQ-1:0] mask, input logic [NREQ-1:0] after,
                         input logic [NREQ-1:0] fin, input int hold);
        logic signed [15:0] oa, ob;
        int n;
        g_gnt = -1; g_wait = 0; g_lat = 0; g_acks = 0; g_starts = 0;
        g_data_bad = 0; g_stab_bad = 0; g_rdy_bad = 0; g_after_valid = 1'b0;
        g_id = '0; g_res = '0; g_err = 1'b0;
        rsp_ready = (hold == 0);
        req_valid = mask;
        #1;
        while (req_ready == '0 && g_wait < 40) begin
            tick();
            g_wait++;
        end
        if (req_ready == '0) begin
            req_valid = '0;
            return;
        end
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) g_gnt = i;
        oa = req_a[g_gnt];
        ob = req_b[g_gnt];
        tick();
        req_valid = after;
        #1;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 60) begin
            if (mul_data_a !== oa || mul_data_b !== ob) g_data_bad++;
            if (req_ready !== '0) g_rdy_bad++;
            if (mul_ack === 1'b1) g_acks++;
            if (mul_start === 1'b1) g_starts++;
            tick();
            n++;
        end
        g_lat = n;
        g_id  = rsp_id;
        g_res = rsp_result;
        g_err = rsp_err;
        if (mul_data_a !== 16'sd0 || mul_data_b !== 16'sd0) g_data_bad++;
        for (int k = 0; k < hold; k++) begin
            if (rsp_valid !== 1'b1 || rsp_id !== g_id || rsp_result !== g_res || rsp_err !== g_err)
                g_stab_bad++;
            if (req_ready !== '0) g_rdy_bad++;
            tick();
        end
        if (rsp_valid !== 1'b1 || rsp_id !== g_id || rsp_result !== g_res || rsp_err !== g_err)
            g_stab_bad++;
        rsp_ready = 1'b1;
        req_valid = fin;
        tick();
        g_after_valid = rsp_valid;
    endtask

    task automatic test_reset();
        resetn    = 1'b0;
        rsp_ready = 1'b0;
        req_valid = '1;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i] = 16'sd1234;
            req_b[i] = -16'sd55;
        end
        tick();
        tick();
        total++; if (req_ready !== '0) begin bad++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
        total++; if ({rsp_valid, rsp_err, mul_start, mul_ack} !== 4'b0) begin bad++;
            $display("FAIL reset_ctrl got=%b exp=0000", {rsp_valid, rsp_err, mul_start, mul_ack}); end
        total++; if (rsp_id !== 2'd0 || rsp_result !== 32'sd0) begin bad++;
            $display("FAIL reset_rsp got id=%0d res=%0d exp 0/0", rsp_id, rsp_result); end
        total++; if (mul_data_a !== 16'sd0 || mul_data_b !== 16'sd0) begin bad++;
            $display("FAIL reset_data got a=%0d b=%0d exp 0/0", mul_data_a, mul_data_b); end
        resetn    = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b1;
        exp_ptr   = 0;
        #1;
        total++; if (mul_irq_enable !== 1'b1) begin bad++; $display("FAIL irq_enable got=%b exp=1", mul_irq_enable); end
        tick();
        total++; if (req_ready !== '0 || rsp_valid !== 1'b0) begin bad++;
            $display("FAIL idle_quiet got rdy=%b vld=%b exp 0", req_ready, rsp_valid); end
    endtask

    task automatic test_single();
        int w;
        req_a[0] = 16'sd3;
        req_b[0] = -16'sd7;
        mul_lat  = 8;
        w = exp_pick(4'b0001);
        do_op(4'b0001, 4'b0000, 4'b0000, 0);
        exp_ptr = (w + 1) % NREQ;
        total++; if (g_gnt !== 0) begin bad++; $display("FAIL single_grant got=%0d exp=0", g_gnt); end
        total++; if (g_lat !== 11) begin bad++; $display("FAIL single_latency got=%0d exp=11", g_lat); end
        total++; if (g_id !== 2'd0) begin bad++; $display("FAIL single_id got=%0d exp=0", g_id); end
        total++; if (g_res !== -32'sd21) begin bad++; $display("FAIL single_result got=%0d exp=-21", g_res); end
        total++; if (g_err !== 1'b0) begin bad++; $display("FAIL single_err got=%b exp=0", g_err); end
        total++; if (g_acks !== 1 || g_starts !== 1) begin bad++;
            $display("FAIL single_pulses got ack=%0d start=%0d exp 1/1", g_acks, g_starts); end
        total++; if (g_data_bad !== 0) begin bad++; $display("FAIL single_operand_bus got=%0d exp=0", g_data_bad); end
        total++; if (g_after_valid !== 1'b0) begin bad++; $display("FAIL single_complete got=%b exp=0", g_after_valid); end
    endtask

    task automatic test_extremes();
        req_a[1] = -16'sd32768; req_b[1] = -16'sd32768;
        do_op(4'b0010, 4'b0000, 4'b0000, 0);
        exp_ptr = 2;
        total++; if (g_res !== 32'sd1073741824) begin bad++;
            $display("FAIL ext_negneg got=%0d exp=1073741824", g_res); end
        req_a[2] = 16'sd32767; req_b[2] = -16'sd32768;
        do_op(4'b0100, 4'b0000, 4'b0000, 0);
        exp_ptr = 3;
        total++; if (g_res !== -32'sd1073709056) begin bad++;
            $display("FAIL ext_posneg got=%0d exp=-1073709056", g_res); end
    endtask

    task automatic test_contention();
        int ord [5] = '{0, 1, 2, 3, 0};
        int w;
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            req_a[i] = 16'(i + 1);
            req_b[i] = 16'sd100;
        end
        for (int k = 0; k < 5; k++) begin
            w = exp_pick(4'b1111);
            do_op(4'b1111, 4'b1111, 4'b1111, 0);
            total++; if (g_gnt !== ord[k] || g_gnt !== w) begin bad++;
                $display("FAIL contention_grant[%0d] got=%0d exp=%0d", k, g_gnt, ord[k]); end
            total++; if (g_res !== (ord[k] + 1) * 100 || g_id !== 2'(ord[k])) begin bad++;
                $display("FAIL contention_rsp[%0d] got id=%0d res=%0d exp id=%0d res=%0d",
                         k, g_id, g_res, ord[k], (ord[k] + 1) * 100); end
            if (k > 0) begin
                total++; if (g_wait !== 0) begin bad++;
                    $display("FAIL back_to_back[%0d] idle_gap got=%0d exp=0", k, g_wait + 1); end
            end
            exp_ptr = (w + 1) % NREQ;
        end
        req_valid = '0;
    endtask

    task automatic test_backpressure();
        int w;
        int quiet_bad;
        req_a[1] = 16'sd1234;
        req_b[1] = -16'sd56;
        w = exp_pick(4'b0010);
        do_op(4'b0010, 4'b1111, 4'b0000, 20);
        exp_ptr = (w + 1) % NREQ;
        total++; if (g_res !== -32'sd69104 || g_id !== 2'd1) begin bad++;
            $display("FAIL bp_result got id=%0d res=%0d exp id=1 res=-69104", g_id, g_res); end
        total++; if (g_stab_bad !== 0) begin bad++; $display("FAIL bp_stable got=%0d exp=0", g_stab_bad); end
        total++; if (g_rdy_bad !== 0) begin bad++; $display("FAIL bp_req_ready got=%0d exp=0", g_rdy_bad); end
        total++; if (g_after_valid !== 1'b0) begin bad++; $display("FAIL bp_complete got=%b exp=0", g_after_valid); end
        quiet_bad = 0;
        for (int k = 0; k < 3; k++) begin
            if (req_ready !== '0 || mul_start !== 1'b0 || rsp_valid !== 1'b0) quiet_bad++;
            tick();
        end
        total++; if (quiet_bad !== 0) begin bad++; $display("FAIL withdrawn_request got=%0d exp=0", quiet_bad); end
    endtask

    task automatic test_timeout();
        int w;
        req_a[2] = 16'sd77; req_b[2] = 16'sd3;
        suppress = 1'b1;
        w = exp_pick(4'b1111);
        do_op(4'b1111, 4'b0000, 4'b0000, 0);
        exp_ptr  = (w + 1) % NREQ;
        suppress = 1'b0;
        total++; if (g_gnt !== w || w !== 2) begin bad++; $display("FAIL timeout_grant got=%0d exp=2", g_gnt); end
        total++; if (g_err !== 1'b1 || g_res !== 32'sd0) begin bad++;
            $display("FAIL timeout_rsp got err=%b res=%0d exp err=1 res=0", g_err, g_res); end
        total++; if (g_acks !== 1) begin bad++; $display("FAIL timeout_ack got=%0d exp=1", g_acks); end
        total++; if (g_lat !== TIMEOUT + 3) begin bad++; $display("FAIL timeout_latency got=%0d exp=%0d", g_lat, TIMEOUT + 3); end
        req_a[3] = -16'sd9; req_b[3] = 16'sd9;
        do_op(4'b1000, 4'b0000, 4'b0000, 0);
        exp_ptr = 0;
        total++; if (g_res !== -32'sd81 || g_err !== 1'b0 || g_lat !== 11) begin bad++;
            $display("FAIL after_timeout got res=%0d err=%b lat=%0d exp -81/0/11", g_res, g_err, g_lat); end
    endtask

    task automatic test_reset_wait();
        int guard;
        int spurious;
        req_a[0] = 16'sd5; req_b[0] = 16'sd6;
        rsp_ready = 1'b1;
        req_valid = 4'b0001;
        #1;
        guard = 0;
        while (req_ready == '0 && guard < 40) begin tick(); guard++; end
        tick();
        req_valid = '0;
        tick(); tick(); tick();
        resetn    = 1'b0;
        req_valid = '1;
        tick();
        total++; if (req_ready !== '0 || rsp_valid !== 1'b0 || mul_start !== 1'b0 || mul_ack !== 1'b0) begin bad++;
            $display("FAIL rstwait_ctrl got rdy=%b vld=%b st=%b ack=%b exp 0", req_ready, rsp_valid, mul_start, mul_ack); end
        total++; if (mul_data_a !== 16'sd0 || mul_data_b !== 16'sd0 || rsp_result !== 32'sd0) begin bad++;
            $display("FAIL rstwait_data got a=%0d b=%0d res=%0d exp 0", mul_data_a, mul_data_b, rsp_result); end
        resetn    = 1'b1;
        req_valid = '0;
        exp_ptr   = 0;
        spurious  = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (rsp_valid !== 1'b0 || mul_start !== 1'b0) spurious++;
        end
        total++; if (spurious !== 0) begin bad++; $display("FAIL rstwait_no_rsp got=%0d exp=0", spurious); end
        req_a[2] = 16'sd11; req_b[2] = -16'sd12;
        do_op(4'b0100, 4'b0000, 4'b0000, 0);
        exp_ptr = 3;
        total++; if (g_gnt !== 2 || g_res !== -32'sd132 || g_lat !== 11) begin bad++;
            $display("FAIL rstwait_next got gnt=%0d res=%0d lat=%0d exp 2/-132/11", g_gnt, g_res, g_lat); end
    endtask

    task automatic test_random();
        logic [NREQ-1:0] m;
        int w, hold, expv;
        for (int it = 0; it < 12; it++) begin
            m = NREQ'($urandom_range(1, 15));
            for (int i = 0; i < NREQ; i++) begin
                req_a[i] = 16'($urandom);
                req_b[i] = 16'($urandom);
            end
            mul_lat = $urandom_range(1, 12);
            hold    = $urandom_range(0, 3);
            w       = exp_pick(m);
            expv    = int'(req_a[w]) * int'(req_b[w]);
            do_op(m, m, 4'b0000, hold);
            exp_ptr = (w + 1) % NREQ;
            total++; if (g_gnt !== w || g_id !== 2'(w)) begin bad++;
                $display("FAIL rand_grant[%0d] got gnt=%0d id=%0d exp=%0d", it, g_gnt, g_id, w); end
            total++; if (g_res !== expv || g_err !== 1'b0) begin bad++;
                $display("FAIL rand_result[%0d] got res=%0d err=%b exp res=%0d err=0", it, g_res, g_err, expv); end
            total++; if (g_lat !== mul_lat + 3 || g_stab_bad !== 0 || g_data_bad !== 0) begin bad++;
                $display("FAIL rand_timing[%0d] got lat=%0d stab=%0d data=%0d exp lat=%0d 0 0",
                         it, g_lat, g_stab_bad, g_data_bad, mul_lat + 3); end
        end
        req_valid = '0;
        mul_lat   = 8;
    endtask

    initial begin
        resetn    = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i] = '0;
            req_b[i] = '0;
        end
        test_reset();
        test_single();
        test_extremes();
        test_contention();
        test_backpressure();
        test_timeout();
        test_reset_wait();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mul_arbiter.md
MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing one radix-4 Booth multiplier; legal range 2..8.
REQ-002 Parameter TIMEOUT, default 15: maximum WAIT cycles allowed without mul_irq before an error response is issued.
REQ-003 clk  input  1: clock; all logic updates on the rising edge.
REQ-004 resetn  input  1: reset, synchronous, active-low.
REQ-005 req_valid  input  NREQ: per-requester operation request.
REQ-006 req_ready  output  NREQ: one-hot grant; acceptance occurs when req_valid[i] and req_ready[i] are both high.
REQ-007 req_a, req_b  input  NREQx16 signed: per-requester operands.
REQ-008 rsp_valid  output  1: response available.
REQ-009 rsp_id  output  clog2(NREQ): index of the requester that owns the response.
REQ-010 rsp_result  output  32 signed: product.
REQ-011 rsp_err  output  1: timeout indication.
REQ-012 rsp_ready  input  1: response consumed.
REQ-013 mul_start, mul_ack, mul_irq_enable  output  1: multiplier controls.
REQ-014 mul_data_a, mul_data_b  output  16 signed: multiplier operands.
REQ-015 mul_busy, mul_irq  input  1: multiplier status.
REQ-016 mul_result  input  32 signed: multiplier product.

Function
REQ-017 The FSM SHALL use the states IDLE, START, WAIT, ACK, DRAIN and RESP.
REQ-018 IDLE: the block SHALL assert req_ready only for the round-robin winner among req_valid bits, searching upward from rr_ptr and wrapping; on acceptance it SHALL latch req_a/req_b and the winner index, then move to START.
REQ-019 rr_ptr SHALL become (winner+1) mod NREQ on each acceptance; it SHALL NOT change otherwise.
REQ-020 START: mul_start SHALL be 1 for exactly one cycle; next state is WAIT.
REQ-021 mul_data_a and mul_data_b SHALL hold the latched operands from START through DRAIN without change; in all other states they SHALL be 0.
REQ-022 mul_irq_enable SHALL be constant 1 after reset.
REQ-023 WAIT: when mul_irq=1, the block SHALL latch mul_result, set err=0 and move to ACK; when TIMEOUT cycles elapse with no mul_irq, it SHALL set result=0, set err=1 and move to ACK.
REQ-024 ACK: mul_ack SHALL be 1 for exactly one cycle; next state is DRAIN.
REQ-025 DRAIN: mul_start SHALL remain 0 until mul_busy=0 is sampled, then the block SHALL move to RESP. This guarantees at least one idle cycle, which clears the multiplier counter and accumulator.
REQ-026 RESP: rsp_valid SHALL be 1, with rsp_id, rsp_result and rsp_err held stable until rsp_ready=1; the block SHALL then return to IDLE.
REQ-027 rsp_valid and rsp_ready high in the same cycle SHALL complete the response; a new request SHALL NOT be accepted in that cycle (req_ready asserts only in IDLE).
REQ-028 Latency: with a nominal multiplier and no backpressure, rsp_valid SHALL first be high in the cycle after the 11th rising edge following the acceptance edge.
REQ-029 Throughput: one operation in flight at most; back-to-back requests SHALL be separated by exactly one IDLE cycle when rsp_ready is held at 1.
REQ-030 A requester that deasserts req_valid before it is granted SHALL lose nothing; no grant or state change SHALL result.

Reset
REQ-031 While resetn=0 at a clock edge, the block SHALL go to IDLE and set rr_ptr=0.
REQ-032 During reset, all outputs SHALL be 0: req_ready, rsp_valid, rsp_id, rsp_result, rsp_err, mul_start, mul_ack, mul_data_a and mul_data_b.
REQ-033 Reset mid-operation SHALL abandon the operation and issue no response; the multiplier shares resetn.

Structure
REQ-034 A shared package mul_pkg SHALL hold the state enum type, operand and product widths (16 and 32), and the default NREQ and TIMEOUT values.
REQ-035 The round-robin winner selection SHALL be a sub-module rr_arbiter (inputs req and ptr; output one-hot grant); the FSM, timeout counter and response registers stay in mul_arbiter.

Verification
REQ-036 Single request: req0 with a=3, b=-7 -> rsp_valid after 11 edges, rsp_id=0, rsp_result=-21, rsp_err=0, and mul_ack pulsed once.
REQ-037 Contention: req_valid=4'b1111 held, operands a=i+1 and b=100 -> grants in order 0,1,2,3,0 with results 100, 200, 300, 400.
REQ-038 Extremes: a=-32768, b=-32768 -> rsp_result=1073741824; a=32767, b=-32768 -> rsp_result=-1073709056.
REQ-039 Backpressure: rsp_ready=0 for 20 cycles -> rsp_valid and rsp_result stable, req_ready all 0 throughout; completion occurs on the first rsp_ready=1.
REQ-040 Timeout: the multiplier model suppresses mul_irq -> after 15 WAIT cycles, rsp_err=1, rsp_result=0, mul_ack pulsed once, and the next request completes correctly.
REQ-041 Reset in WAIT: resetn=0 for one edge -> all outputs 0 and no response issued; a following request to req2 is granted first and completes.
